// File: rtl/rvh_pmp_check_ctrl_if.sv
// Request and response channels between the MMU/LSU address path and the PMP check controller.
interface rvh_pmp_check_ctrl_if #(
    parameter int PMP_ENTRY_COUNT = 16,
    parameter int PADDR_WIDTH     = 56,
    parameter int TRANS_ID_WIDTH  = 4,
    parameter int IDX_W           = $clog2(PMP_ENTRY_COUNT)
);
    logic                      req_vld_i;
    logic                      req_rdy_o;
    logic [PADDR_WIDTH-1:0]    req_paddr_i;
    logic [1:0]                req_access_type_i;
    logic                      req_priv_m_i;
    logic [TRANS_ID_WIDTH-1:0] req_id_i;

    logic                      resp_vld_o;
    logic                      resp_rdy_i;
    logic [TRANS_ID_WIDTH-1:0] resp_id_o;
    logic [PADDR_WIDTH-1:0]    resp_paddr_o;
    logic                      resp_fault_o;
    logic                      resp_match_vld_o;
    logic [IDX_W-1:0]          resp_match_idx_o;

    modport master (
        output req_vld_i, req_paddr_i, req_access_type_i, req_priv_m_i, req_id_i, resp_rdy_i,
        input  req_rdy_o, resp_vld_o, resp_id_o, resp_paddr_o, resp_fault_o,
               resp_match_vld_o, resp_match_idx_o
    );

    modport slave (
        input  req_vld_i, req_paddr_i, req_access_type_i, req_priv_m_i, req_id_i, resp_rdy_i,
        output req_rdy_o, resp_vld_o, resp_id_o, resp_paddr_o, resp_fault_o,
               resp_match_vld_o, resp_match_idx_o
    );
endinterface

// File: rtl/rvh_pmp_check_ctrl.sv
// Two-stage PMP check controller: S1 broadcasts the request to all entries and resolves
// their answers by lowest-index priority, S2 holds the registered fault response.

module rvh_pmp_entry_resolve (
    input  logic match,
    input  logic fail,
    input  logic lock,
    input  logic lower_hit,
    input  logic priv_m,
    output logic win,
    output logic deny
);
    assign win  = match & ~lower_hit;
    // M-mode is only constrained by locked entries.
    assign deny = fail & (~priv_m | lock);
endmodule

module rvh_pmp_check_ctrl #(
    parameter int PMP_ENTRY_COUNT = 16,
    parameter int PADDR_WIDTH     = 56,
    parameter int TRANS_ID_WIDTH  = 4,
    parameter int IDX_W           = $clog2(PMP_ENTRY_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    rvh_pmp_check_ctrl_if.slave         pmp_bus,
    output logic                        permission_check_vld_o,
    output logic [PADDR_WIDTH-1:0]      permission_check_paddr_o,
    output logic [1:0]                  permission_check_access_type_o,
    input  logic [PMP_ENTRY_COUNT-1:0]  entry_match_i,
    input  logic [PMP_ENTRY_COUNT-1:0]  entry_fail_i,
    input  logic [PMP_ENTRY_COUNT-1:0]  entry_lock_i,
    output logic [15:0]                 fault_cnt_o
);
    typedef struct packed {
        logic [PADDR_WIDTH-1:0]    paddr;
        logic [1:0]                access_type;
        logic                      priv_m;
        logic [TRANS_ID_WIDTH-1:0] id;
    } req_t;

    typedef struct packed {
        logic [TRANS_ID_WIDTH-1:0] id;
        logic [PADDR_WIDTH-1:0]    paddr;
        logic                      fault;
        logic                      match_vld;
        logic [IDX_W-1:0]          match_idx;
    } resp_t;

    // vld_pipe[1] = S1 valid, vld_pipe[2] = response valid
    logic [2:1]  vld_pipe;
    req_t        s1_q;
    req_t        req_in;
    resp_t       s2_q;
    resp_t       s1_res;
    logic [15:0] fault_cnt_q;

    logic s2_free, s1_adv, accept, resp_hs;

    assign s2_free           = ~vld_pipe[2] | pmp_bus.resp_rdy_i;
    assign s1_adv            = vld_pipe[1] & s2_free;
    assign pmp_bus.req_rdy_o = ~flush_i & (~vld_pipe[1] | s1_adv);
    assign accept            = pmp_bus.req_vld_i & pmp_bus.req_rdy_o;
    assign resp_hs           = vld_pipe[2] & pmp_bus.resp_rdy_i;

    always_comb begin
        req_in             = '0;
        req_in.paddr       = pmp_bus.req_paddr_i;
        req_in.access_type = pmp_bus.req_access_type_i;
        req_in.priv_m      = pmp_bus.req_priv_m_i;
        req_in.id          = pmp_bus.req_id_i;
    end

    assign permission_check_vld_o         = vld_pipe[1];
    assign permission_check_paddr_o       = s1_q.paddr;
    assign permission_check_access_type_o = s1_q.access_type;

    // lower_hit[i] means some entry below i already matched.
    logic [PMP_ENTRY_COUNT:0]   lower_hit;
    logic [PMP_ENTRY_COUNT-1:0] win;
    logic [PMP_ENTRY_COUNT-1:0] deny;
    logic [IDX_W-1:0]           win_idx;
    logic                       any_hit;

    assign lower_hit[0] = 1'b0;

    for (genvar i = 0; i < PMP_ENTRY_COUNT; i++) begin : g_ent
        rvh_pmp_entry_resolve u_resolve (
            .match     (entry_match_i[i]),
            .fail      (entry_fail_i[i]),
            .lock      (entry_lock_i[i]),
            .lower_hit (lower_hit[i]),
            .priv_m    (s1_q.priv_m),
            .win       (win[i]),
            .deny      (deny[i])
        );
        assign lower_hit[i+1] = lower_hit[i] | entry_match_i[i];
    end

    assign any_hit = lower_hit[PMP_ENTRY_COUNT];

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < PMP_ENTRY_COUNT; i++)
            if (win[i]) win_idx = win_idx | IDX_W'(i);
    end

    always_comb begin
        s1_res           = '0;
        s1_res.id        = s1_q.id;
        s1_res.paddr     = s1_q.paddr;
        s1_res.match_vld = any_hit;
        s1_res.match_idx = win_idx;
        // Unmatched accesses are allowed only in M-mode; access type 3 is always denied.
        s1_res.fault     = (s1_q.access_type == 2'd3) |
                           (any_hit ? |(win & deny) : ~s1_q.priv_m);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (flush_i) begin
                vld_pipe <= '0;
            end else begin
                if (accept)      vld_pipe[1] <= 1'b1;
                else if (s1_adv) vld_pipe[1] <= 1'b0;
                if (s1_adv)       vld_pipe[2] <= 1'b1;
                else if (resp_hs) vld_pipe[2] <= 1'b0;
            end
            if (accept) s1_q <= req_in;
            if (s1_adv) s2_q <= s1_res;
        end
    end

    // A handshake coinciding with a flush still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_cnt_q <= '0;
        else if (resp_hs & s2_q.fault & ~&fault_cnt_q)
            fault_cnt_q <= fault_cnt_q + 16'd1;
    end

    assign pmp_bus.resp_vld_o       = vld_pipe[2];
    assign pmp_bus.resp_id_o        = s2_q.id;
    assign pmp_bus.resp_paddr_o     = s2_q.paddr;
    assign pmp_bus.resp_fault_o     = s2_q.fault;
    assign pmp_bus.resp_match_vld_o = s2_q.match_vld;
    assign pmp_bus.resp_match_idx_o = s2_q.match_idx;
    assign fault_cnt_o              = fault_cnt_q;

    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        vld_pipe[2] & ~pmp_bus.resp_rdy_i & ~flush_i |=> vld_pipe[2] && $stable(s2_q));

    a_win_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(win));
endmodule

// File: tb/tb_rvh_pmp_check_ctrl.sv
// Randomized bench for rvh_pmp_check_ctrl against an in-order response scoreboard.
module tb_rvh_pmp_check_ctrl;
    localparam int N  = 16;
    localparam int PW = 56;
    localparam int TW = 4;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [PW-1:0] paddr;
        logic [1:0]    atype;
        logic          priv;
        logic [TW-1:0] id;
    } rq_t;

    typedef struct {
        logic [TW-1:0] id;
        logic [PW-1:0] paddr;
        logic          fault;
        logic          mv;
        logic [IW-1:0] idx;
        int            acc;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic          pc_vld;
    logic [PW-1:0] pc_paddr;
    logic [1:0]    pc_type;
    logic [N-1:0]  e_match, e_fail, e_lock;
    logic [15:0]   fault_cnt;

    // Entry environment: either fixed vectors or address-range regions.
    logic          fix_en = 1'b1;
    logic [N-1:0]  fix_m = '0, fix_f = '0, fix_l = '0;
    logic [PW-1:0] base [N];
    logic [PW-1:0] size [N];
    logic [3:0]    perm [N];
    logic [N-1:0]  lck;

    ex_t         q[$];
    ex_t         last, got;
    int          n_chk = 0, n_err = 0, cur = 0;
    logic [15:0] cnt_m = '0;
    bit          a, h;

    always #5 clk = ~clk;

    rvh_pmp_check_ctrl_if #(.PMP_ENTRY_COUNT(N), .PADDR_WIDTH(PW), .TRANS_ID_WIDTH(TW)) bus ();

    rvh_pmp_check_ctrl #(.PMP_ENTRY_COUNT(N), .PADDR_WIDTH(PW), .TRANS_ID_WIDTH(TW)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .flush_i                        (flush),
        .pmp_bus                        (bus),
        .permission_check_vld_o         (pc_vld),
        .permission_check_paddr_o       (pc_paddr),
        .permission_check_access_type_o (pc_type),
        .entry_match_i                  (e_match),
        .entry_fail_i                   (e_fail),
        .entry_lock_i                   (e_lock),
        .fault_cnt_o                    (fault_cnt)
    );

    always_comb begin
        e_match = fix_m;
        e_fail  = fix_f;
        e_lock  = fix_l;
        if (!fix_en)
            for (int i = 0; i < N; i++) begin
                e_match[i] = (pc_paddr >= base[i]) && (pc_paddr < base[i] + size[i]);
                e_fail[i]  = ~perm[i][pc_type];
                e_lock[i]  = lck[i];
            end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first matching region in index order decides, privilege rules on top.
    function automatic ex_t model(input rq_t r, input int stamp);
        ex_t e;
        logic m, f, l;
        e.id = r.id; e.paddr = r.paddr; e.acc = stamp;
        e.mv = 1'b0; e.idx = '0; e.fault = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (fix_en) begin
                m = fix_m[i]; f = fix_f[i]; l = fix_l[i];
            end else begin
                m = (r.paddr >= base[i]) && (r.paddr < base[i] + size[i]);
                f = (r.atype == 2'd3) || !perm[i][r.atype];
                l = lck[i];
            end
            if (m) begin
                e.mv = 1'b1;
                e.idx = IW'(i);
                e.fault = r.priv ? (f && l) : f;
            end
        end
        if (!e.mv) e.fault = !r.priv;
        if (r.atype == 2'd3) e.fault = 1'b1;
        return e;
    endfunction

    function automatic rq_t mk(input logic [PW-1:0] pa, input logic [1:0] t,
                               input logic p, input logic [TW-1:0] id);
        rq_t r;
        r.paddr = pa; r.atype = t; r.priv = p; r.id = id;
        return r;
    endfunction

    task automatic step(input bit rv, input rq_t r, input bit rr, input bit fl,
                        output bit acc, output bit hs);
        bit ev;
        @(negedge clk);
        bus.req_vld_i         = rv;
        bus.req_paddr_i       = r.paddr;
        bus.req_access_type_i = r.atype;
        bus.req_priv_m_i      = r.priv;
        bus.req_id_i          = r.id;
        bus.resp_rdy_i        = rr;
        flush                 = fl;
        #1;
        ev = (q.size() > 0) && (q[0].acc != cur - 1);
        chk("resp_vld", bus.resp_vld_o, ev);
        chk("req_rdy", bus.req_rdy_o, !fl && (q.size() < 2 || rr));
        chk("fault_cnt", fault_cnt, cnt_m);
        hs  = bus.resp_vld_o && rr;
        acc = rv && bus.req_rdy_o;
        if (hs) begin
            got.id = bus.resp_id_o; got.paddr = bus.resp_paddr_o; got.fault = bus.resp_fault_o;
            got.mv = bus.resp_match_vld_o; got.idx = bus.resp_match_idx_o; got.acc = 0;
            if (q.size() == 0) begin
                chk("resp_unexpected", bus.resp_vld_o, 0);
            end else begin
                last = q.pop_front();
                chk("resp_id", got.id, last.id);
                chk("resp_paddr", got.paddr, last.paddr);
                chk("resp_fault", got.fault, last.fault);
                chk("resp_match_vld", got.mv, last.mv);
                chk("resp_match_idx", got.idx, last.idx);
                if (last.fault && cnt_m != 16'hFFFF) cnt_m++;
            end
        end
        if (fl) q.delete();
        if (acc) q.push_back(model(r, cur));
        cur++;
        @(posedge clk);
    endtask

    task automatic idle(input bit rr);
        step(0, '0, rr, 0, a, h);
    endtask

    // Single request with resp_rdy held high: response must appear exactly 2 cycles later.
    task automatic one(input rq_t r);
        step(1, r, 1, 0, a, h);
        chk("one_accept", a, 1);
        step(0, '0, 1, 0, a, h);
        chk("one_early", h, 0);
        step(0, '0, 1, 0, a, h);
        chk("one_resp", h, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int na, nh, idn;
        logic [15:0] fc0;
        rq_t r;

        bus.req_vld_i = 0; bus.req_paddr_i = '0; bus.req_access_type_i = '0;
        bus.req_priv_m_i = 0; bus.req_id_i = '0; bus.resp_rdy_i = 0;
        for (int i = 0; i < N; i++) begin
            base[i] = PW'($urandom_range(0, 1000));
            size[i] = PW'($urandom_range(8, 200));
            perm[i] = {1'b0, 3'($urandom)};
            lck[i]  = 1'($urandom);
        end

        #22;
        chk("rst_resp_vld", bus.resp_vld_o, 0);
        chk("rst_pc_vld", pc_vld, 0);
        chk("rst_pc_paddr", pc_paddr, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_resp_id", bus.resp_id_o, 0);
        @(negedge clk);
        rst = 0;

        // Lowest-index winner: entries 3 and 5 match, entry 3 fails.
        fix_m = 16'h0028; fix_f = 16'h0008; fix_l = '0;
        one(mk(56'h1234, 2'd1, 0, 4'h7));
        chk("t1_fault", got.fault, 1);
        chk("t1_idx", got.idx, 3);
        chk("t1_id", got.id, 7);

        fix_m = '0; fix_f = '0;
        one(mk(56'h40, 2'd0, 1, 4'h1));
        chk("nomatch_m_fault", got.fault, 0);
        chk("nomatch_m_mv", got.mv, 0);
        one(mk(56'h40, 2'd0, 0, 4'h2));
        chk("nomatch_u_fault", got.fault, 1);
        one(mk(56'h40, 2'd3, 1, 4'h3));
        chk("illegal_type_fault", got.fault, 1);

        fix_m = 16'h0004; fix_f = 16'h0004; fix_l = '0;
        one(mk(56'h80, 2'd2, 1, 4'h4));
        chk("m_unlocked_fault", got.fault, 0);
        fix_l = 16'h0004;
        one(mk(56'h80, 2'd2, 1, 4'h5));
        chk("m_locked_fault", got.fault, 1);
        chk("m_locked_idx", got.idx, 2);

        // Backpressure: 5 cycles of resp_rdy=0 admit only 2 requests.
        na = 0; idn = 8;
        for (int k = 0; k < 5; k++) begin
            step(1, mk(56'h100, 2'd0, 0, 4'(idn)), 0, 0, a, h);
            if (a) begin idn++; na++; end
        end
        chk("bp_accepts", na, 2);
        nh = 0;
        for (int k = 0; k < 4; k++) begin
            step(na < 4, mk(56'h100, 2'd0, 0, 4'(idn)), 1, 0, a, h);
            if (a) begin idn++; na++; end
            if (h) nh++;
        end
        chk("bp_drain_hs", nh, 4);
        chk("bp_total_acc", na, 4);

        // Flush with 2 faulting requests in flight.
        fix_m = '0; fix_f = '0; fix_l = '0;
        step(1, mk(56'h200, 2'd1, 0, 4'hA), 0, 0, a, h);
        step(1, mk(56'h208, 2'd1, 0, 4'hB), 0, 0, a, h);
        fc0 = cnt_m;
        step(1, mk(56'h210, 2'd1, 0, 4'hC), 0, 1, a, h);
        chk("flush_blocks_accept", a, 0);
        nh = 0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (h) nh++;
        end
        chk("flush_no_resp", nh, 0);
        chk("flush_cnt", fault_cnt, fc0);
        one(mk(56'h300, 2'd0, 0, 4'hD));
        chk("post_flush_id", got.id, 4'hD);

        // Random traffic against address-range regions.
        fix_en = 0;
        for (int k = 0; k < 400; k++) begin
            r.paddr = ($urandom_range(0, 7) == 0) ? PW'({$urandom, $urandom})
                                                  : PW'($urandom_range(0, 1150));
            r.atype = 2'($urandom);
            r.priv  = 1'($urandom);
            r.id    = TW'($urandom);
            step($urandom_range(0, 9) < 7, r, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, a, h);
        end
        for (int k = 0; k < 4; k++) idle(1);

        // Saturation from 0xFFFE.
        fix_en = 1; fix_m = '0;
        @(negedge clk);
        force dut.fault_cnt_q = 16'hFFFE;
        #1;
        release dut.fault_cnt_q;
        cnt_m = 16'hFFFE;
        for (int k = 0; k < 3; k++) step(1, mk(56'h50, 2'd0, 0, 4'(k)), 1, 0, a, h);
        for (int k = 0; k < 3; k++) idle(1);
        chk("sat_cnt", fault_cnt, 16'hFFFF);

        // Asynchronous reset with requests in flight.
        step(1, mk(56'h60, 2'd1, 0, 4'h6), 0, 0, a, h);
        step(1, mk(56'h68, 2'd1, 0, 4'h9), 0, 0, a, h);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_resp_vld", bus.resp_vld_o, 0);
        chk("arst_resp_id", bus.resp_id_o, 0);
        chk("arst_resp_paddr", bus.resp_paddr_o, 0);
        chk("arst_resp_fault", bus.resp_fault_o, 0);
        chk("arst_match_vld", bus.resp_match_vld_o, 0);
        chk("arst_match_idx", bus.resp_match_idx_o, 0);
        chk("arst_pc_vld", pc_vld, 0);
        chk("arst_pc_paddr", pc_paddr, 0);
        chk("arst_pc_type", pc_type, 0);
        chk("arst_fault_cnt", fault_cnt, 0);
        q.delete();
        cnt_m = '0;
        @(negedge clk);
        rst = 0;
        bus.req_vld_i = 0;
        idle(1);
        one(mk(56'h70, 2'd0, 1, 4'hE));
        chk("post_rst_id", got.id, 4'hE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
